cache_ctrl: RTL and testbench

//  Sequences a direct-mapped, write-through, single-word-block cache between the CPU load/store port and main memory.

---
 rtl/cache_ctrl.sv | 139 +++++++++++++
 tb/tb_cache_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through cache sequencer (tag/valid store, miss handling, memory handshake)
// Optional perf counters: define CACHE_PERF_CNT_EN.
module cache_ctrl #(
  parameter int SETLEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              inv_all,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [SETLEN-1:0] arr_idx,
  output logic              arr_we,
  output logic [31:0]       arr_wdata,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses,
`endif
  input  logic [31:0]       arr_rdata
);

  localparam int SETS = 1 << SETLEN;
  localparam int TAGW = 30 - SETLEN;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, DONE} state_t;

  state_t            state;
  logic [TAGW-1:0]   tags [SETS];
  logic [SETS-1:0]   valid;
  logic [31:0]       rdata_q;

  logic [SETLEN-1:0] idx;
  logic [TAGW-1:0]   tag;
  logic              hit;
  logic              lookup;
  logic              unused_bits;

  assign idx         = cpu_addr[SETLEN+1:2];
  assign tag         = cpu_addr[31:SETLEN+2];
  assign hit         = valid[idx] && (tags[idx] == tag);
  assign lookup      = (state == IDLE) && cpu_req;
  assign unused_bits = ^cpu_addr[1:0];

  assign mem_addr  = {cpu_addr[31:2], 2'b00};
  assign mem_wdata = cpu_wdata;
  assign arr_idx   = idx;

  // Hits and the store-hit array update must be visible in the lookup cycle itself.
  always_comb begin
    cpu_stall = 1'b0;
    arr_we    = 1'b0;
    arr_wdata = cpu_wdata;
    cpu_rdata = arr_rdata;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          cpu_stall = cpu_we || !hit;
          arr_we    = cpu_we && hit;
        end
      end
      RD_MISS: begin
        cpu_stall = 1'b1;
        arr_we    = mem_ack;
        arr_wdata = mem_rdata;
      end
      WR_MEM: cpu_stall = 1'b1;
      DONE:   cpu_rdata = rdata_q;
      default: cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      rdata_q <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Lookup above already used the pre-clear valid bits.
          if (inv_all) valid <= '0;
          if (cpu_req) begin
            if (cpu_we) begin
              state   <= WR_MEM;
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
            end else if (!hit) begin
              state   <= RD_MISS;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            tags[idx]  <= tag;
            valid[idx] <= 1'b1;
            rdata_q    <= mem_rdata;
            mem_req    <= 1'b0;
            state      <= DONE;
          end
        end
        WR_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (lookup) begin
      if (hit) perf_hits   <= perf_hits + 32'd1;
      else     perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with memory and data-array models
// Perf counter checks compile in when CACHE_PERF_CNT_EN is defined.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, inv_all;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  arr_idx;
  logic        arr_we;
  logic [31:0] arr_wdata, arr_rdata;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  always #5 clk = ~clk;

  cache_ctrl #(.SETLEN(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .inv_all(inv_all),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .arr_idx(arr_idx), .arr_we(arr_we), .arr_wdata(arr_wdata),
`ifdef CACHE_PERF_CNT_EN
    .perf_hits(perf_hits), .perf_misses(perf_misses),
`endif
    .arr_rdata(arr_rdata)
  );

  // External data array: registered write, combinational read.
  logic [31:0] darr [8];
  assign arr_rdata = darr[arr_idx];
  always @(posedge clk) if (arr_we) darr[arr_idx] <= arr_wdata;

  // Main memory: acks in the lat-th cycle of a held request.
  logic [31:0] mem [logic [31:0]];
  int lat = 1;
  int req_cyc = 0;
  always @(negedge clk) begin
    if (mem_req && !mem_ack) begin
      req_cyc++;
      if (req_cyc >= lat) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      end
    end else begin
      mem_ack   = 1'b0;
      req_cyc   = 0;
      mem_rdata = $urandom;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] data;
    int          stalls;
  } txn_t;
  txn_t sb[$];

  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_hit, input int l, input logic inv);
    txn_t        t;
    int          stalls = 0;
    int          awe = 0;
    logic        mseen = 1'b0;
    logic        mwe = 1'b0;
    logic        done = 1'b0;
    logic [31:0] aidx = '0;
    logic [31:0] maddr = '0;
    logic [31:0] aligned;
    logic [31:0] got = '0;
    aligned = {addr[31:2], 2'b00};
    lat = l;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; inv_all = inv;
    t.we     = we;
    t.data   = mem.exists(aligned) ? mem[aligned] : 32'h0;
    t.stalls = (!we && exp_hit) ? 0 : l + 1;
    sb.push_back(t);
    if (exp_hit) exp_hits++; else exp_misses++;
    #1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (arr_we) begin awe++; aidx = {29'd0, arr_idx}; end
      if (mem_req && !mseen) begin mseen = 1'b1; maddr = mem_addr; mwe = mem_we; end
      if (!cpu_stall) begin
        done = 1'b1;
        got  = cpu_rdata;
      end else begin
        stalls++;
        @(negedge clk);
        #1;
      end
    end
    check("timeout", {31'd0, done}, 32'd1);
    t = sb.pop_front();
    check("stall_cycles", stalls, t.stalls);
    if (!t.we) check("cpu_rdata", got, t.data);
    check("arr_we_cycles", awe, ((we && exp_hit) || (!we && !exp_hit)) ? 1 : 0);
    if (awe != 0) check("arr_idx", aidx, {29'd0, addr[4:2]});
    check("mem_req_seen", {31'd0, mseen}, {31'd0, !(!we && exp_hit)});
    if (mseen) begin
      check("mem_addr", maddr, aligned);
      check("mem_we", {31'd0, mwe}, {31'd0, we});
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    inv_all = 1'b0;
    check("post_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; inv_all = 1'b0;
    mem[32'h10]  = 32'hDEAD_BEEF;
    mem[32'h30]  = 32'hCAFE_0030;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_arr_we", {31'd0, arr_we}, 32'd0);
    rst = 1'b0;

    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 3, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b1, 3, 1'b0);
    access(1'b0, 32'h0000_0030, 32'h0, 1'b0, 2, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1, 1'b0);
    access(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 2, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b1, 2, 1'b0);
    access(1'b1, 32'h0000_0100, 32'hA5A5_0100, 1'b0, 3, 1'b0);
    access(1'b0, 32'h0000_0103, 32'h0, 1'b0, 4, 1'b0);

    // Invalidate while idle, then hit-with-invalidate, then the miss it causes.
    @(negedge clk); inv_all = 1'b1;
    @(negedge clk); inv_all = 1'b0;
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 2, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b1, 2, 1'b1);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 2, 1'b0);

    // Reset in the middle of a read miss.
    lat = 20;
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0030;
    repeat (2) @(negedge clk);
    #1;
    check("mid_mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    #1;
    check("rst_drop_req", {31'd0, mem_req}, 32'd0);
    check("rst_drop_stall", {31'd0, cpu_stall}, 32'd0);
    rst = 1'b0;
    exp_hits = 0; exp_misses = 0;
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b1, 1, 1'b0);
    access(1'b0, 32'h0000_0030, 32'h0, 1'b0, 2, 1'b0);
`ifdef CACHE_PERF_CNT_EN
    check("perf_hits", perf_hits, exp_hits);
    check("perf_misses", perf_misses, exp_misses);
`endif
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
